// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier, one multiplier bit per clock
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] m_reg;
    logic             c_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   sum;

    // Conditional add of M into {C,A}; C is always zero here so the sum cannot overflow WIDTH+1 bits
    always_comb begin
        sum = {c_reg, a_reg};
        if (q_reg[0]) begin
            sum = {c_reg, a_reg} + {1'b0, m_reg};
        end
    end

    // Control FSM and datapath: capture on start, add-then-shift-right in RUN, one-cycle DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            m_reg   <= '0;
            c_reg   <= 1'b0;
            a_reg   <= '0;
            q_reg   <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        c_reg <= 1'b0;
                        a_reg <= '0;
                        count <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // {C,A,Q} <= {0, sum, Q[W-1:1]}: the sum's LSB drops into the top of Q
                    c_reg <= 1'b0;
                    a_reg <= sum[WIDTH:1];
                    q_reg <= {sum[0], q_reg[WIDTH-1:1]};
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        product <= {sum[WIDTH:1], sum[0], q_reg[WIDTH-1:1]};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // back-to-back: accept the next operands without an idle gap
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        c_reg <= 1'b0;
                        a_reg <= '0;
                        count <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - randomized and directed self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start4 = 1'b0;
    logic [3:0]  mc4 = '0;
    logic [3:0]  mp4 = '0;
    logic        busy4;
    logic        done4;
    logic [7:0]  prod4;
    logic        start8 = 1'b0;
    logic [7:0]  mc8 = '0;
    logic [7:0]  mp8 = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] prod8;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .multiplicand(mc4), .multiplier(mp4),
        .busy(busy4), .done(done4), .product(prod4)
    );

    shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .multiplicand(mc8), .multiplier(mp8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // One multiplication: start accepted at edge N, done expected in cycle N+w+1, busy for w cycles
    task automatic mul(input int w, input logic [7:0] a, input logic [7:0] b);
        int          c;
        int          nbusy;
        int          overlap;
        logic        dn;
        logic        bz;
        logic [15:0] p;
        logic [15:0] exp_p;
        @(negedge clk);
        if (w == 4) begin start4 = 1'b1; mc4 = a[3:0]; mp4 = b[3:0]; end
        else        begin start8 = 1'b1; mc8 = a;      mp8 = b;      end
        c = 0; nbusy = 0; overlap = 0; dn = 1'b0; p = '0;
        while (!dn && c < 40) begin
            @(negedge clk);
            start4 = 1'b0; start8 = 1'b0;
            c++;
            dn = (w == 4) ? done4 : done8;
            bz = (w == 4) ? busy4 : busy8;
            p  = (w == 4) ? {8'b0, prod4} : prod8;
            if (bz) nbusy++;
            if (bz && dn) overlap++;
        end
        exp_p = 16'(a) * 16'(b);
        if (w == 4) exp_p = 16'(a[3:0]) * 16'(b[3:0]);
        check($sformatf("w%0d %0d*%0d latency", w, a, b), c, w + 1);
        check($sformatf("w%0d %0d*%0d product", w, a, b), p, exp_p);
        check($sformatf("w%0d %0d*%0d busy cycles", w, a, b), nbusy, w);
        check($sformatf("w%0d busy/done overlap", w), overlap, 0);
    endtask

    initial begin
        int first_c;
        int second_c;
        logic [7:0] first_p;
        logic [7:0] second_p;
        logic [7:0] mid_p;
        logic [7:0] ra;
        logic [7:0] rb;

        repeat (2) @(negedge clk);
        check("reset busy", busy4, 0);
        check("reset done", done4, 0);
        check("reset product", prod4, 0);
        rst = 1'b0;

        mul(4, 8'd13, 8'd11);
        @(negedge clk);
        check("done single pulse", done4, 0);
        check("product held in idle", prod4, 8'h8F);
        mul(4, 8'd15, 8'd15);
        mul(4, 8'd0, 8'd9);
        mul(4, 8'd9, 8'd0);

        // start held high through RUN with different operands
        @(negedge clk);
        start4 = 1'b1; mc4 = 4'd3; mp4 = 4'd5;
        first_c = 0; second_c = 0; first_p = '0; second_p = '0; mid_p = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            mc4 = 4'd7; mp4 = 4'd2;
            if (k == 6) start4 = 1'b0;
            if (k == 7) mid_p = prod4;
            if (done4) begin
                if (first_c == 0) begin first_c = k; first_p = prod4; end
                else if (second_c == 0) begin second_c = k; second_p = prod4; end
            end
        end
        start4 = 1'b0;
        check("held start first done", first_c, 5);
        check("held start first product", first_p, 15);
        check("held start product held in run", mid_p, 15);
        check("held start second done", second_c, 10);
        check("held start second product", second_p, 14);

        // reset during cycle 2 of RUN discards the partial result and clears product
        @(negedge clk);
        start4 = 1'b1; mc4 = 4'd6; mp4 = 4'd7;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-run reset busy", busy4, 0);
        check("mid-run reset done", done4, 0);
        check("mid-run reset product", prod4, 0);
        mul(4, 8'd6, 8'd7);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 15));
            rb = 8'($urandom_range(0, 15));
            mul(4, ra, rb);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            mul(8, ra, rb);
        end
        mul(8, 8'd255, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
